// File: rtl/core_pkg.sv
// ----------------------------------------------------------------------------
// core_pkg
//   Shared core definitions used by the register-tracking unit: default
//   register width and count, the default register-address type and the
//   hardwired-zero register index.
// ----------------------------------------------------------------------------
package core_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = $clog2(NREG_DEF);

  typedef logic [AW_DEF-1:0] reg_addr_t;

  localparam reg_addr_t REG_X0 = '0;

endpackage : core_pkg

// File: rtl/core_rtu_sb_bank.sv
// ----------------------------------------------------------------------------
// core_rtu_sb_bank
//   NREG x XLEN integer register storage with NWR write ports and NRD
//   combinational read ports. Register 0 is never written and always reads 0.
//   When several write ports target the same register in one cycle, the
//   highest port index wins.
//
// Ports
//   clk_i      core clock
//   rst_n_i    asynchronous active-low reset, clears every register
//   wb_vld_i   write valid per port
//   wb_addr_i  write addresses, port j at [j*AW +: AW]
//   wb_data_i  write data, port j at [j*XLEN +: XLEN]
//   rd_addr_i  read addresses, port k at [k*AW +: AW]
//   rd_data_o  committed read data, port k at [k*XLEN +: XLEN]
// ----------------------------------------------------------------------------
module core_rtu_sb_bank
  import core_pkg::*;
#(
  parameter  int XLEN = XLEN_DEF,
  parameter  int NREG = NREG_DEF,
  parameter  int NRD  = 2,
  parameter  int NWR  = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [NWR-1:0]       wb_vld_i,
  input  logic [NWR*AW-1:0]    wb_addr_i,
  input  logic [NWR*XLEN-1:0]  wb_data_i,
  input  logic [NRD*AW-1:0]    rd_addr_i,
  output logic [NRD*XLEN-1:0]  rd_data_o
);

  logic [XLEN-1:0] mem_q [NREG];
  logic [XLEN-1:0] wr_data [NREG];
  logic [NREG-1:0] wr_en;

  // Per-register write enable and data. Ports are scanned in ascending order
  // so a later (higher-index) port overrides an earlier one.
  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    wr_en = '0;
    for (int r = 0; r < NREG; r++) wr_data[r] = '0;
    for (int j = 0; j < NWR; j++) begin
      for (int r = 1; r < NREG; r++) begin
        if (wb_vld_i[j] && wb_addr_i[j*AW +: AW] == AW'(r)) begin
          wr_en[r]   = 1'b1;
          wr_data[r] = wb_data_i[j*XLEN +: XLEN];
        end
      end
    end
  end

  // NOTE: the register file is reset explicitly because the architectural
  // state must read zero after reset; this rules out a RAM macro but is what
  // the pipeline relies on.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples its inputs from the same pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int r = 0; r < NREG; r++) mem_q[r] <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (wr_en[r]) mem_q[r] <= wr_data[r];
      end
    end
  end

  // Read mux by compare rather than direct indexing keeps out-of-range
  // addresses (non power-of-two NREG) and x0 reading zero.
  always_comb begin
    rd_data_o = '0;
    for (int k = 0; k < NRD; k++) begin
      for (int r = 1; r < NREG; r++) begin
        if (rd_addr_i[k*AW +: AW] == AW'(r)) rd_data_o[k*XLEN +: XLEN] = mem_q[r];
      end
    end
  end

endmodule : core_rtu_sb_bank

// File: rtl/core_rtu_sb.sv
// ----------------------------------------------------------------------------
// core_rtu_sb
//   Register-tracking unit: multi-port register file plus per-register busy
//   scoreboard. Issue claims a destination (stalls on WAW), write-back clears
//   the claim and commits data, flush drops all claims.
//
//   Build option RTU_BYPASS_EN: same-cycle write-back forwarding to the read
//   ports (data and busy) and to the issue-ready check. Without it, reads and
//   issue see committed state only.
//
// Ports
//   clk_i       core clock
//   rst_n_i     asynchronous active-low reset
//   rd_addr_i   read addresses, port k at [k*AW +: AW]
//   rd_data_o   read data, port k at [k*XLEN +: XLEN]
//   rd_busy_o   per read port: source register has a pending write
//   iss_vld_i   issue request claiming iss_addr_i
//   iss_addr_i  destination register of the issuing instruction
//   iss_rdy_o   issue can be accepted this cycle (independent of iss_vld_i)
//   wb_vld_i    write-back valid per port
//   wb_addr_i   write-back addresses, port j at [j*AW +: AW]
//   wb_data_i   write-back data, port j at [j*XLEN +: XLEN]
//   flush_i     drop all pending claims (write-back data still commits)
//   busy_o      full scoreboard vector, bit 0 always 0
// ----------------------------------------------------------------------------
module core_rtu_sb
  import core_pkg::*;
#(
  parameter  int XLEN = XLEN_DEF,
  parameter  int NREG = NREG_DEF,
  parameter  int NRD  = 2,
  parameter  int NWR  = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [NRD*AW-1:0]    rd_addr_i,
  output logic [NRD*XLEN-1:0]  rd_data_o,
  output logic [NRD-1:0]       rd_busy_o,
  input  logic                 iss_vld_i,
  input  logic [AW-1:0]        iss_addr_i,
  output logic                 iss_rdy_o,
  input  logic [NWR-1:0]       wb_vld_i,
  input  logic [NWR*AW-1:0]    wb_addr_i,
  input  logic [NWR*XLEN-1:0]  wb_data_i,
  input  logic                 flush_i,
  output logic [NREG-1:0]      busy_o
);

  logic [NREG-1:0]     busy_q;
  logic [NREG-1:0]     busy_d;
  logic [NREG-1:0]     wb_clr;
  logic [NREG-1:0]     iss_set;
  logic [NRD*XLEN-1:0] bank_rd_data;

  core_rtu_sb_bank #(
    .XLEN (XLEN),
    .NREG (NREG),
    .NRD  (NRD),
    .NWR  (NWR)
  ) u_bank (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .wb_vld_i  (wb_vld_i),
    .wb_addr_i (wb_addr_i),
    .wb_data_i (wb_data_i),
    .rd_addr_i (rd_addr_i),
    .rd_data_o (bank_rd_data)
  );

  // Registers hit by any valid write-back this cycle (x0 excluded).
  always_comb begin
    wb_clr = '0;
    for (int j = 0; j < NWR; j++) begin
      for (int r = 1; r < NREG; r++) begin
        if (wb_vld_i[j] && wb_addr_i[j*AW +: AW] == AW'(r)) wb_clr[r] = 1'b1;
      end
    end
  end

  // Issue: stall only on a pending write to the destination (WAW). x0 is
  // always ready and never claimed.
  always_comb begin
    iss_rdy_o = 1'b1;
    iss_set   = '0;
    for (int r = 1; r < NREG; r++) begin
      if (iss_addr_i == AW'(r)) begin
`ifdef RTU_BYPASS_EN
        iss_rdy_o  = ~busy_q[r] | wb_clr[r];
`else
        iss_rdy_o  = ~busy_q[r];
`endif
        iss_set[r] = iss_vld_i & iss_rdy_o;
      end
    end
  end

  // Busy next state: flush beats a new claim, a new claim beats a
  // write-back clear (the new producer owns the register).
  always_comb begin
    busy_d = '0;
    for (int r = 1; r < NREG; r++) begin
      if (flush_i)         busy_d[r] = 1'b0;
      else if (iss_set[r]) busy_d[r] = 1'b1;
      else if (wb_clr[r])  busy_d[r] = 1'b0;
      else                 busy_d[r] = busy_q[r];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  assign busy_o = busy_q;

  // Read ports: committed data and busy, optionally overridden by a
  // same-cycle write-back (highest matching port wins, as in the bank).
  always_comb begin
    rd_data_o = bank_rd_data;
    rd_busy_o = '0;
    for (int k = 0; k < NRD; k++) begin
      for (int r = 1; r < NREG; r++) begin
        if (rd_addr_i[k*AW +: AW] == AW'(r)) begin
          rd_busy_o[k] = busy_q[r];
`ifdef RTU_BYPASS_EN
          // Forwarding is held off during reset so outputs read zero.
          if (wb_clr[r] && rst_n_i) begin
            rd_busy_o[k] = 1'b0;
            for (int j = 0; j < NWR; j++) begin
              if (wb_vld_i[j] && wb_addr_i[j*AW +: AW] == AW'(r))
                rd_data_o[k*XLEN +: XLEN] = wb_data_i[j*XLEN +: XLEN];
            end
          end
`endif
        end
      end
    end
  end

endmodule : core_rtu_sb
